copy_engine: RTL

Word-granular memory-to-memory copy engine driven by the `str_cpy` / `done_cpy` handshake. A rising edge on `str_cpy` latches source, destination and length. The engine then moves the words one at a time over a simple valid/ready read port and write port. When the copy completes or aborts, it emits a single-cycle `done_cpy` pulse. It sits between the enclave-side control registers, which raise `str_cpy` and consume the resulting `done` status, and the shared memory fabric.

---
 rtl/copy_engine_pkg.sv | 19 +
 rtl/copy_engine_edge_detect_rise.sv | 25 ++
 rtl/copy_engine.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/copy_engine_pkg.sv
// Shared types and constants for the word-granular copy engine.
package copy_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int DEFAULT_DATA_W = 32;
  localparam int BYTES_PER_WORD = DEFAULT_DATA_W / 8;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/copy_engine_edge_detect_rise.sv
// One-flop rising-edge detector; rise is combinational and valid in the cycle d first reads 1.
// No flow control: the previous value is tracked every cycle regardless of consumer state.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb d_d = d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/copy_engine.sv
// Memory-to-memory word copy started by a rising edge on str_cpy; 3 cycles per word with ready high.
// Each stalled cycle on the read-request or write channel adds exactly one cycle; one read in flight.
module copy_engine
  import copy_engine_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              aclk,
  input  logic              nreset,
  input  logic              str_cpy,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              done_cpy,
  output logic              busy,
  output logic              err,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_err,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_err
);

  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(bytes_per_word(DATA_W));

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              rd_vld_q, rd_vld_d;
  logic              wr_vld_q, wr_vld_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              str_rise;

  edge_detect_rise u_str_edge (
    .clk   (aclk),
    .rst_n (nreset),
    .d     (str_cpy),
    .rise  (str_rise)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (str_rise) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = len_words;
          err_d   = 1'b0;
          state_d = (len_words == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (rd_req_ready) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_data_valid) begin
          data_d = rd_data;
          if (rd_data_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (wr_ready) begin
          if (wr_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Addresses wrap modulo 2^ADDR_W by plain truncating addition.
            src_d   = src_q + ADDR_INC;
            dst_d   = dst_q + ADDR_INC;
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rd_vld_d = (state_d == ST_RD_REQ);
    wr_vld_d = (state_d == ST_WR_REQ);
    done_d   = (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      wr_vld_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      err_q    <= err_d;
      rd_vld_q <= rd_vld_d;
      wr_vld_q <= wr_vld_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign rd_req_valid = rd_vld_q;
  assign rd_req_addr  = src_q;
  assign wr_valid     = wr_vld_q;
  assign wr_addr      = dst_q;
  assign wr_data      = data_q;
  assign done_cpy     = done_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
